// File: rtl/kinase_ctrl_sequencer.sv
// kinase_ctrl_sequencer: valve-mask / settle / peristaltic pump / dwell step sequencer (optional PUMP_REVERSE_EN adds cmd_reverse)
module kinase_ctrl_sequencer #(
  parameter int PHASE_CYCLES  = 1000,
  parameter int SETTLE_CYCLES = 5000,
  parameter int CYC_W         = 8,
  parameter int DWELL_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [16:0]        cmd_valves,
  input  logic [1:0]         cmd_pump,
  input  logic [CYC_W-1:0]   cmd_cycles,
  input  logic [DWELL_W-1:0] cmd_dwell,
`ifdef PUMP_REVERSE_EN
  input  logic               cmd_reverse,
`endif
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [CYC_W-1:0]   cycles_done,
  output logic [12:0]        ctrl_a,
  output logic [3:0]         ctrl_s,
  output logic [2:0]         pump_a,
  output logic [1:0]         pump_b
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] PUMP   = 3'd2;
  localparam logic [2:0] DWELL  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] ABORT  = 3'd5;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int PW  = $clog2(PHASE_CYCLES + 1);
  localparam int TW0 = SW > PW ? SW : PW;
  localparam int TW  = TW0 > DWELL_W ? TW0 : DWELL_W;
  // phase tables packed p5..p0, so phase p lives at bit offset width*p
  localparam logic [17:0] TAB_A = {3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011};
  localparam logic [11:0] TAB_B = {2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
  logic [2:0]         state_q, state_d, p_q, p_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d, cyc_inc, ncyc_q;
  logic [1:0]         pump_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [16:0]        ctrl_q;
  logic [2:0]         pa_q;
  logic [1:0]         pb_q;
  logic               ready_q, busy_q, done_q, ab_q;
  logic               rev, accept, go_pump;
  logic [2:0]         after_pump, p_first, p_last;
`ifdef PUMP_REVERSE_EN
  logic rev_q;
  // direction is latched with the rest of the command
  always_ff @(posedge clk)
    if (rst) rev_q <= 1'b0;
    else if (accept) rev_q <= cmd_reverse;
  assign rev = rev_q;
`else
  assign rev = 1'b0;
`endif
  assign accept     = state_q == IDLE && cmd_valid;
  assign go_pump    = pump_q != 2'b00 && ncyc_q != '0;
  assign after_pump = dwell_q != '0 ? DWELL : DONE;
  assign p_first    = rev ? 3'd5 : 3'd0;
  assign p_last     = rev ? 3'd0 : 3'd5;
  assign cyc_inc    = cyc_q + CYC_W'(1);
  // step FSM: a single down-counter times settle, each phase and the dwell
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - TW'(1);
    p_d     = p_q;
    cyc_d   = cyc_q;
    if (state_q != IDLE && abort) state_d = ABORT;
    else case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = SETTLE;
        cnt_d   = TW'(SETTLE_CYCLES - 1);
        cyc_d   = '0;
      end
      SETTLE: if (cnt_q == '0) begin
        state_d = go_pump ? PUMP : after_pump;
        cnt_d   = go_pump ? TW'(PHASE_CYCLES - 1) : TW'(dwell_q) - TW'(1);
        p_d     = p_first;
      end
      PUMP: if (cnt_q == '0) begin
        cnt_d = TW'(PHASE_CYCLES - 1);
        p_d   = rev ? p_q - 3'd1 : p_q + 3'd1;
        if (p_q == p_last) begin
          cyc_d = cyc_inc;
          p_d   = p_first;
          if (cyc_inc == ncyc_q) begin
            state_d = after_pump;
            cnt_d   = TW'(dwell_q) - TW'(1);
          end
        end
      end
      DWELL: if (cnt_q == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // state, command latch and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      cyc_q   <= '0;
      pump_q  <= '0;
      ncyc_q  <= '0;
      dwell_q <= '0;
      ctrl_q  <= '1;
      pa_q    <= '1;
      pb_q    <= '1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      cyc_q   <= cyc_d;
      if (accept) begin
        pump_q  <= cmd_pump;
        ncyc_q  <= cmd_cycles;
        dwell_q <= cmd_dwell;
      end
      ctrl_q  <= accept ? cmd_valves : state_d == ABORT ? '1 : ctrl_q;
      pa_q    <= state_d == PUMP && pump_q[0] ? TAB_A[3*p_d +: 3] : 3'b111;
      pb_q    <= state_d == PUMP && pump_q[1] ? TAB_B[2*p_d +: 2] : 2'b11;
      ready_q <= state_d == IDLE;
      busy_q  <= state_d == SETTLE || state_d == PUMP || state_d == DWELL;
      done_q  <= state_d == DONE;
      ab_q    <= state_d == ABORT;
    end
  end
  assign cmd_ready   = ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = ab_q;
  assign cycles_done = cyc_q;
  assign ctrl_a      = ctrl_q[12:0];
  assign ctrl_s      = ctrl_q[16:13];
  assign pump_a      = pa_q;
  assign pump_b      = pb_q;
endmodule

// File: tb/tb_kinase_ctrl_sequencer.sv
// tb_kinase_ctrl_sequencer: randomized and directed checks of the step sequencer against a timeline model
module tb_kinase_ctrl_sequencer;
  localparam int PH = 2;
  localparam int ST = 3;
  typedef struct packed {
    logic busy; logic done; logic ab; logic rdy;
    logic [7:0] cd; logic [16:0] ctrl; logic [2:0] pa; logic [1:0] pb;
  } obs_t;
  logic clk = 0, rst = 1, cmd_valid = 0, abort = 0;
  logic [16:0] cmd_valves = '0;
  logic [1:0] cmd_pump = '0;
  logic [7:0] cmd_cycles = '0;
  logic [15:0] cmd_dwell = '0;
  logic cmd_ready, busy, done, aborted;
  logic [7:0] cycles_done;
  logic [12:0] ctrl_a;
  logic [3:0] ctrl_s;
  logic [2:0] pump_a;
  logic [1:0] pump_b;
  obs_t obs;
  int checks = 0, errors = 0;
  logic [2:0] TA [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
  logic [1:0] TB [6] = '{2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b11};
  kinase_ctrl_sequencer #(.PHASE_CYCLES(PH), .SETTLE_CYCLES(ST), .CYC_W(8), .DWELL_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_valves(cmd_valves),
    .cmd_pump(cmd_pump), .cmd_cycles(cmd_cycles), .cmd_dwell(cmd_dwell), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .cycles_done(cycles_done),
    .ctrl_a(ctrl_a), .ctrl_s(ctrl_s), .pump_a(pump_a), .pump_b(pump_b)
  );
  assign obs = {busy, done, aborted, cmd_ready, cycles_done, ctrl_s, ctrl_a, pump_a, pump_b};
  always #5 clk = ~clk;
  // cycle of the done pulse, counted from the acceptance cycle
  function automatic int step_len(logic [1:0] pm, int cyc, int dw);
    return 1 + ST + ((pm != 0 && cyc != 0) ? 6 * PH * cyc : 0) + dw;
  endfunction
  // expected outputs k cycles after acceptance; large k gives the idle picture
  function automatic obs_t model(int k, logic [16:0] v, logic [1:0] pm, int cyc, int dw);
    obs_t e;
    int ce, j, dk;
    ce = (pm != 0 && cyc != 0) ? cyc : 0;
    dk = step_len(pm, cyc, dw);
    j = k - 1 - ST;
    e.busy = k < dk;
    e.done = k == dk;
    e.ab = 1'b0;
    e.rdy = k > dk;
    e.ctrl = v;
    e.pa = 3'b111;
    e.pb = 2'b11;
    e.cd = (j < 0) ? 8'd0 : 8'(ce);
    if (j >= 0 && j < 6 * PH * ce) begin
      e.cd = 8'(j / (6 * PH));
      if (pm[0]) e.pa = TA[(j / PH) % 6];
      if (pm[1]) e.pb = TB[(j / PH) % 6];
    end
    return e;
  endfunction
  task automatic send(logic [16:0] v, logic [1:0] pm, int cyc, int dw);
    cmd_valves = v;
    cmd_pump = pm;
    cmd_cycles = 8'(cyc);
    cmd_dwell = 16'(dw);
    cmd_valid = 1;
    @(posedge clk);
  endtask
  task automatic test_reset();
    obs_t e;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    e = model(1000, 17'h1FFFF, 2'b00, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset got %h exp %h", obs, e); end
    rst = 0;
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release got %h exp %h", obs, e); end
  endtask
  task automatic test_basic();
    obs_t e;
    int dk;
    dk = step_len(2'b01, 2, 4);
    send(17'h00F0F, 2'b01, 2, 4);
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      e = model(k, 17'h00F0F, 2'b01, 2, 4);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL basic k=%0d got %h exp %h", k, obs, e); end
    end
  endtask
  task automatic test_zero_work();
    obs_t e;
    int dk;
    for (int i = 0; i < 4; i++) begin
      dk = step_len(2'(i), 0, 0);
      send(17'h0A5A5 ^ 17'(i), 2'(i), 0, 0);
      for (int k = 1; k <= dk + 1; k++) begin
        @(negedge clk);
        if (k == 1) cmd_valid = 0;
        e = model(k, 17'h0A5A5 ^ 17'(i), 2'(i), 0, 0);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL zero_work pm=%0d k=%0d got %h exp %h", i, k, obs, e); end
      end
    end
  endtask
  task automatic test_both_pumps();
    obs_t e;
    int dk;
    dk = step_len(2'b11, 1, 0);
    send(17'h15555, 2'b11, 1, 0);
    for (int k = 1; k <= dk + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      e = model(k, 17'h15555, 2'b11, 1, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL both_pumps k=%0d got %h exp %h", k, obs, e); end
    end
  endtask
  task automatic test_abort();
    obs_t e;
    send(17'h0A5A5, 2'b10, 0, 0);
    for (int k = 1; k <= step_len(2'b10, 0, 0) + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    e = model(1000, 17'h0A5A5, 2'b10, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL abort_idle got %h exp %h", obs, e); end
    send(17'h01234, 2'b01, 2, 3);
    for (int k = 1; k <= 1 + ST + 3 * PH; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      e = model(k, 17'h01234, 2'b01, 2, 3);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL abort_pre k=%0d got %h exp %h", k, obs, e); end
    end
    abort = 1;
    cmd_valid = 1;
    cmd_valves = 17'h00000;
    @(negedge clk);
    abort = 0;
    cmd_valid = 0;
    e = model(1000, 17'h1FFFF, 2'b00, 0, 0);
    e.ab = 1'b1;
    e.rdy = 1'b0;
    checks++;
    if (obs[32:0] !== e[32:0]) begin errors++; $display("FAIL abort_cycle got %h exp %h", obs[32:0], e[32:0]); end
    e = model(1000, 17'h1FFFF, 2'b00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL abort_after k=%0d got %h exp %h", k, obs, e); end
    end
  endtask
  task automatic test_back_to_back();
    obs_t e;
    int da, db;
    da = step_len(2'b01, 1, 2);
    db = step_len(2'b10, 1, 0);
    send(17'h0F0F0, 2'b01, 1, 2);
    for (int k = 1; k <= da + 1; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valves = 17'h10001;
        cmd_pump = 2'b10;
        cmd_cycles = 8'd1;
        cmd_dwell = 16'd0;
      end
      e = model(k, 17'h0F0F0, 2'b01, 1, 2);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b_first k=%0d got %h exp %h", k, obs, e); end
    end
    for (int k = 1; k <= db + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
      e = model(k, 17'h10001, 2'b10, 1, 0);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b_second k=%0d got %h exp %h", k, obs, e); end
    end
  endtask
  task automatic test_random();
    obs_t e;
    logic [16:0] v;
    logic [1:0] pm;
    int cyc, dw, dk;
    for (int i = 0; i < 12; i++) begin
      v = 17'($urandom);
      pm = 2'($urandom);
      cyc = $urandom_range(0, 3);
      dw = $urandom_range(0, 9);
      dk = step_len(pm, cyc, dw);
      send(v, pm, cyc, dw);
      for (int k = 1; k <= dk + 1; k++) begin
        @(negedge clk);
        if (k == 1) cmd_valid = 0;
        e = model(k, v, pm, cyc, dw);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL random i=%0d k=%0d got %h exp %h", i, k, obs, e); end
      end
    end
  endtask
  task automatic test_reset_mid();
    obs_t e;
    int stop;
    stop = $urandom_range(ST + 2, step_len(2'b11, 2, 5) - 1);
    send(17'h00001, 2'b11, 2, 5);
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 0;
    end
    rst = 1;
    @(negedge clk);
    e = model(1000, 17'h1FFFF, 2'b00, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid at=%0d got %h exp %h", stop, obs, e); end
    rst = 0;
    @(negedge clk);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_mid_after got %h exp %h", obs, e); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_zero_work();
    test_both_pumps();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
